// File: rtl/compressor_pkg.sv
// compressor_pkg: shared defaults, FSM state type and width helper for the compressor front end
package compressor_pkg;

    localparam int DEF_N_SRC = 20;
    localparam int DEF_W     = 20;
    localparam int DEF_DST_W = 25;
    localparam int DEF_LAT   = 0;

    typedef enum logic [1:0] {LOAD, SHIFT, WAIT, DONE} state_t;

    // index width for n entries, never narrower than one bit
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_bank.sv
// operand_bank: N_SRC x W operand storage with a word write port and a bit-column read port
module operand_bank #(
    parameter int N_SRC = 20,
    parameter int W     = 20,
    parameter int AW    = 5,
    parameter int IW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [W-1:0]     wdata,
    input  logic [IW-1:0]    rbit,
    output logic [N_SRC-1:0] rcol
);

    logic [W-1:0] mem [N_SRC];

    // word writes; reset clears every lane so an aborted frame leaves nothing behind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_col
        assign rcol[i] = mem[i][rbit];
    end

endmodule

// File: rtl/compressor_load_sequencer.sv
// compressor_load_sequencer: loads N_SRC operands, shifts them MSB-first into the serial lanes, captures the compressor sum
module compressor_load_sequencer
    import compressor_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC,
    parameter int W     = DEF_W,
    parameter int DST_W = DEF_DST_W,
    parameter int LAT   = DEF_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic [N_SRC-1:0] ser,
    input  logic [DST_W-1:0] res_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DST_W-1:0] out_data,
    output logic             busy
);

    localparam int CW = idx_w(N_SRC);
    localparam int IW = idx_w(W);
    localparam int BW = $clog2(W + 1);
    localparam int WW = $clog2(LAT + 2);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bcnt;
    logic [WW-1:0]     wcnt;
    logic [IW-1:0]     ridx;
    logic [N_SRC-1:0]  col, ser_nxt;
    logic              load_hs, load_last, shift_last, wait_last, out_hs;

    assign load_hs    = state == LOAD && in_valid;
    assign load_last  = load_hs && cnt == CW'(N_SRC - 1);
    assign shift_last = state == SHIFT && bcnt == BW'(W - 1);
    assign wait_last  = state == WAIT && wcnt == WW'(LAT);
    assign out_hs     = state == DONE && out_ready;

    // ser is registered one cycle ahead: the last-operand edge already presents the MSB column,
    // so the final lane's bit comes straight from in_data while it is still being written
    assign ridx    = state == LOAD ? IW'(W - 1) : IW'(W - 2 - int'(bcnt));
    assign ser_nxt = state == LOAD ? {in_data[W-1], col[N_SRC-2:0]} : col;

    operand_bank #(
        .N_SRC(N_SRC),
        .W    (W),
        .AW   (CW),
        .IW   (IW)
    ) u_bank (
        .clk  (clk),
        .rst  (rst),
        .we   (load_hs),
        .waddr(cnt),
        .wdata(in_data),
        .rbit (ridx),
        .rcol (col)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // next state: each exit condition is already qualified by its own state
    always_comb begin
        state_nxt = load_last ? SHIFT : shift_last ? WAIT : wait_last ? DONE : out_hs ? LOAD : state;
    end

    // lane, shift-bit and wait counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            bcnt <= '0;
            wcnt <= '0;
        end else begin
            if (load_hs) cnt <= load_last ? '0 : cnt + 1'b1;
            bcnt <= state == SHIFT ? bcnt + 1'b1 : '0;
            wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
        end
    end

    // serial lanes carry a column for W cycles and idle low otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ser <= '0;
        else     ser <= load_last || (state == SHIFT && !shift_last) ? ser_nxt : '0;
    end

    // capture the sum on the edge that ends the last WAIT cycle and hold it through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            out_data <= '0;
        else if (wait_last) out_data <= res_in;
    end

    // handshake and status outputs decoded from state
    always_comb begin
        in_ready  = state == LOAD;
        out_valid = state == DONE;
        busy      = state != LOAD || cnt != '0;
    end

endmodule
